// File: rtl/sw_debounce.sv
// Per-channel two-flop synchroniser and counter-based debouncer for raw slide switches.
// Produces clean levels, registered one-cycle rise/fall pulses and a settled flag.
module sw_debounce #(
   parameter int unsigned CH              = 3,
   parameter int unsigned DEBOUNCE_CYCLES = 2000000,
   parameter int unsigned CNT_W           = 21,
   parameter logic        INIT_LEVEL      = 1'b0
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [CH-1:0] sw_in,
   output logic [CH-1:0] sw_db,
   output logic [CH-1:0] sw_rise,
   output logic [CH-1:0] sw_fall,
   output logic          settled
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [CH-1:0]            r_s1;
   logic [CH-1:0]            r_s2;
   logic [CH-1:0]            r_db;
   logic [CH-1:0]            r_rise;
   logic [CH-1:0]            r_fall;
   logic                     r_settled;
   logic [CH-1:0][CNT_W-1:0] r_cnt;

   logic [CH-1:0]            w_diff;
   logic [CH-1:0]            w_done;
   logic [CH-1:0][CNT_W-1:0] w_cnt_nxt;

   assign w_diff = r_s2 ^ r_db;

   // A counter only advances while the synchronised level disagrees with the
   // accepted one; agreement or acceptance returns it to zero.
   always_comb begin
      w_done    = '0;
      w_cnt_nxt = '0;
      for (int unsigned i = 0; i < CH; i++) begin
         if (w_diff[i]) begin
            if (r_cnt[i] == LAST) begin
               w_done[i] = 1'b1;
            end else begin
               w_cnt_nxt[i] = r_cnt[i] + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1      <= {CH{INIT_LEVEL}};
         r_s2      <= {CH{INIT_LEVEL}};
         r_db      <= {CH{INIT_LEVEL}};
         r_rise    <= '0;
         r_fall    <= '0;
         r_settled <= 1'b1;
         r_cnt     <= '0;
      end else begin
         r_s1      <= sw_in;
         r_s2      <= r_s1;
         r_db      <= r_db ^ w_done;
         r_rise    <= w_done & r_s2;
         r_fall    <= w_done & ~r_s2;
         r_settled <= ~|w_diff;
         r_cnt     <= w_cnt_nxt;
      end
   end

   assign sw_db   = r_db;
   assign sw_rise = r_rise;
   assign sw_fall = r_fall;
   assign settled = r_settled;

endmodule

// File: tb/tb_sw_debounce.sv
// Directed and randomised checks of sw_debounce against a sliding-window reference model.
module tb_sw_debounce;

   localparam int D = 8;

   logic       clk;
   logic       rst_n;
   logic [2:0] sw_in;
   logic [2:0] sw_db;
   logic [2:0] sw_rise;
   logic [2:0] sw_fall;
   logic       settled;

   int n_chk  = 0;
   int n_fail = 0;

   sw_debounce #(
      .CH              (3),
      .DEBOUNCE_CYCLES (8),
      .CNT_W           (4),
      .INIT_LEVEL      (1'b0)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .sw_in   (sw_in),
      .sw_db   (sw_db),
      .sw_rise (sw_rise),
      .sw_fall (sw_fall),
      .settled (settled)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference: a channel flips once its last D synchronised samples since the
   // previous flip all disagree with the accepted level.
   bit [2:0] m_s1, m_s2, m_db, m_rise, m_fall;
   bit       m_set;
   bit       m_q[3][$];

   function automatic bit maj(input logic [2:0] v);
      return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_s1 = '0; m_s2 = '0; m_db = '0; m_rise = '0; m_fall = '0; m_set = 1'b1;
      for (int c = 0; c < 3; c++) m_q[c].delete();
   endtask

   task automatic model_edge(input bit [2:0] vin);
      bit [2:0] acc;
      bit       flip;
      acc   = '0;
      m_set = (m_s2 == m_db);
      for (int c = 0; c < 3; c++) begin
         m_q[c].push_back(m_s2[c]);
         if (m_q[c].size() > D) void'(m_q[c].pop_front());
         if (m_q[c].size() == D) begin
            flip = 1'b1;
            for (int j = 0; j < D; j++) if (m_q[c][j] == m_db[c]) flip = 1'b0;
            if (flip) begin
               acc[c] = 1'b1;
               m_q[c].delete();
            end
         end
      end
      m_rise = acc & m_s2;
      m_fall = acc & ~m_s2;
      m_db   = m_db ^ acc;
      m_s2   = m_s1;
      m_s1   = vin;
   endtask

   task automatic step(input logic [2:0] v);
      sw_in = v;
      @(posedge clk);
      model_edge(v);
      #1;
      chk("model_db", sw_db, m_db);
      chk("model_rise", sw_rise, m_rise);
      chk("model_fall", sw_fall, m_fall);
      chk("model_settled", settled, m_set);
      chk("rise_fall_excl", sw_rise & sw_fall, 3'b000);
      chk("voter", maj(sw_db), maj(m_db));
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #2;
      model_reset();
      chk("rst_db", sw_db, 3'b000);
      chk("rst_rise", sw_rise, 3'b000);
      chk("rst_fall", sw_fall, 3'b000);
      chk("rst_settled", settled, 1'b1);
      chk("rst_cnt", dut.r_cnt, 12'h000);
      #10;
      rst_n = 1'b1;
   endtask

   initial begin
      int unsigned seg_len;
      logic [2:0]  seg_val;
      rst_n = 1'b1;
      sw_in = 3'b000;
      model_reset();
      #3;
      do_reset();

      // Clean edge on channel 0
      for (int k = 0; k < 12; k++) begin
         step(3'b001);
         chk("clean_db", sw_db, (k >= 9) ? 3'b001 : 3'b000);
         chk("clean_rise", sw_rise, (k == 9) ? 3'b001 : 3'b000);
         if (k >= 3 && k <= 9) chk("clean_settled_lo", settled, 1'b0);
         if (k >= 10) chk("clean_settled_hi", settled, 1'b1);
      end

      // Bounce rejection on channel 1
      for (int p = 0; p < 4; p++)
         for (int k = 0; k < 3; k++) begin
            step((p % 2 == 0) ? 3'b011 : 3'b001);
            chk("bounce_db", sw_db, 3'b001);
            chk("bounce_edges", sw_rise | sw_fall, 3'b000);
         end
      for (int k = 0; k < 12; k++) begin
         step(3'b001);
         chk("bounce_db_tail", sw_db, 3'b001);
         chk("bounce_edges_tail", sw_rise | sw_fall, 3'b000);
      end
      chk("bounce_settled", settled, 1'b1);

      // Bounce then hold on channel 2
      for (int p = 0; p < 4; p++)
         for (int k = 0; k < 5; k++) begin
            step((p % 2 == 0) ? 3'b101 : 3'b001);
            chk("bh_db2_bounce", sw_db[2], 1'b0);
            chk("bh_rise2_bounce", sw_rise[2], 1'b0);
         end
      for (int k = 0; k < 12; k++) begin
         step(3'b101);
         chk("bh_db2", sw_db[2], (k >= 9) ? 1'b1 : 1'b0);
         chk("bh_rise2", sw_rise[2], (k == 9) ? 1'b1 : 1'b0);
      end

      // Simultaneous channels
      for (int k = 0; k < 12; k++) step(3'b000);
      chk("sim_clear", sw_db, 3'b000);
      for (int k = 0; k < 12; k++) begin
         step(3'b111);
         chk("sim_db", sw_db, (k >= 9) ? 3'b111 : 3'b000);
         chk("sim_rise", sw_rise, (k == 9) ? 3'b111 : 3'b000);
      end
      for (int k = 0; k < 12; k++) begin
         step(3'b010);
         chk("sim_db2", sw_db, (k >= 9) ? 3'b010 : 3'b111);
         chk("sim_fall", sw_fall, (k == 9) ? 3'b101 : 3'b000);
         chk("sim_rise2", sw_rise, 3'b000);
      end

      // Reset while channel 2 is mid-count
      for (int k = 0; k < 7; k++) step(3'b100);
      chk("mid_cnt5", dut.r_cnt[2], 4'd5);
      sw_in = 3'b100;
      do_reset();
      for (int k = 0; k < 12; k++) begin
         step(3'b100);
         chk("post_rst_db", sw_db, (k >= 9) ? 3'b100 : 3'b000);
         chk("post_rst_rise", sw_rise, (k == 9) ? 3'b100 : 3'b000);
         chk("post_rst_fall", sw_fall, 3'b000);
      end

      // Voter integration, then a short glitch on channel 0
      for (int k = 0; k < 12; k++) begin
         step(3'b011);
         chk("vote_result", maj(sw_db), (k >= 9) ? 1'b1 : 1'b0);
      end
      for (int k = 0; k < 3; k++) begin
         step(3'b010);
         chk("vote_glitch", maj(sw_db), 1'b1);
      end
      for (int k = 0; k < 12; k++) begin
         step(3'b011);
         chk("vote_hold", maj(sw_db), 1'b1);
         chk("vote_db", sw_db, 3'b011);
      end

      // Randomised segments of varying dwell
      for (int s = 0; s < 60; s++) begin
         seg_val = 3'($urandom_range(0, 7));
         seg_len = $urandom_range(1, 14);
         for (int unsigned k = 0; k < seg_len; k++) step(seg_val);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
